// File: rtl/cmp_peak_tracker.sv
// Streaming peak tracker wrapped around an external 16-bit magnitude comparator.
// Each sample is compared first against the running maximum, then against the
// running minimum. Both comparisons are given a fixed number of settle cycles
// before their result is captured.
module cmp_peak_tracker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic [15:0] cmp_a,
  output logic [15:0] cmp_b,
  input  logic        cmp_gt,
  input  logic        cmp_eq,
  input  logic        cmp_lt,
  output logic [15:0] max_val,
  output logic [15:0] min_val,
  output logic [15:0] count,
  output logic        have_data,
  output logic        out_valid,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StCmpMax, StCmpMin} state_e;

  // Counter value at which the comparator result is captured.
  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] sample_q, sample_d;
  logic [15:0] new_max_q, new_max_d;
  logic [15:0] cmp_a_q, cmp_a_d;
  logic [15:0] cmp_b_q, cmp_b_d;
  logic [15:0] max_q, max_d;
  logic [15:0] min_q, min_d;
  logic [15:0] count_q, count_d;
  logic        have_q, have_d;
  logic        out_valid_q, out_valid_d;
  logic        err_q, err_d;

  logic accept;
  logic res_onehot;

  assign in_ready   = (state_q == StIdle) & ~clear;
  assign accept     = in_valid & in_ready;
  assign res_onehot = ({cmp_gt, cmp_eq, cmp_lt} == 3'b100) ||
                      ({cmp_gt, cmp_eq, cmp_lt} == 3'b010) ||
                      ({cmp_gt, cmp_eq, cmp_lt} == 3'b001);

  // Next-state logic: clear dominates, then the accept/compare sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sample_d    = sample_q;
    new_max_d   = new_max_q;
    cmp_a_d     = cmp_a_q;
    cmp_b_d     = cmp_b_q;
    max_d       = max_q;
    min_d       = min_q;
    count_d     = count_q;
    have_d      = have_q;
    out_valid_d = 1'b0;
    err_d       = err_q;

    if (clear) begin
      state_d   = StIdle;
      cnt_d     = '0;
      sample_d  = '0;
      new_max_d = '0;
      cmp_a_d   = '0;
      cmp_b_d   = '0;
      max_d     = '0;
      min_d     = '0;
      count_d   = '0;
      have_d    = 1'b0;
      err_d     = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (!have_q) begin
              // First sample seeds both extremes without using the comparator.
              max_d       = in_data;
              min_d       = in_data;
              count_d     = 16'd1;
              have_d      = 1'b1;
              out_valid_d = 1'b1;
            end else begin
              sample_d = in_data;
              cmp_a_d  = in_data;
              cmp_b_d  = max_q;
              cnt_d    = '0;
              state_d  = StCmpMax;
            end
          end
        end
        StCmpMax: begin
          if (cnt_q == SettleLast) begin
            if (!res_onehot) begin
              err_d   = 1'b1;
              state_d = StIdle;
            end else begin
              new_max_d = cmp_gt ? sample_q : max_q;
              cmp_b_d   = min_q;
              cnt_d     = '0;
              state_d   = StCmpMin;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        StCmpMin: begin
          if (cnt_q == SettleLast) begin
            if (!res_onehot) begin
              err_d   = 1'b1;
              state_d = StIdle;
            end else begin
              max_d       = new_max_q;
              min_d       = cmp_lt ? sample_q : min_q;
              count_d     = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
              out_valid_d = 1'b1;
              state_d     = StIdle;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and statistics registers, asynchronously reset to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sample_q    <= '0;
      new_max_q   <= '0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      max_q       <= '0;
      min_q       <= '0;
      count_q     <= '0;
      have_q      <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sample_q    <= sample_d;
      new_max_q   <= new_max_d;
      cmp_a_q     <= cmp_a_d;
      cmp_b_q     <= cmp_b_d;
      max_q       <= max_d;
      min_q       <= min_d;
      count_q     <= count_d;
      have_q      <= have_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign cmp_a     = cmp_a_q;
  assign cmp_b     = cmp_b_q;
  assign max_val   = max_q;
  assign min_val   = min_q;
  assign count     = count_q;
  assign have_data = have_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: doc/cmp_peak_tracker.md
# cmp_peak_tracker

Streaming 16-bit peak tracker that sits directly around the 16-bit magnitude comparator. It accepts samples on a valid/ready handshake and drives the comparator's `a`/`b` inputs with each sample against the running maximum, then against the running minimum. It waits a fixed number of cycles for the comparator to settle, captures `a_gt_b`/`a_eq_b`/`a_lt_b`, and updates the maximum, minimum and sample-count registers. It is the sequential front end that makes the comparator usable in the clocked datapath.

## Interface
- `SETTLE_CYCLES`, default 2: clock edges the comparator outputs are allowed to settle before capture. Legal range 1..15.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous clear of all statistics; highest priority after reset.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a sample. Equals (state==IDLE) & ~`clear`.
- `in_data`  in  16  unsigned sample.
- `cmp_a`  out  16  registered; drives comparator `a`.
- `cmp_b`  out  16  registered; drives comparator `b`.
- `cmp_gt`  in  1  comparator `a_gt_b`.
- `cmp_eq`  in  1  comparator `a_eq_b`.
- `cmp_lt`  in  1  comparator `a_lt_b`.
- `max_val`  out  16  running maximum.
- `min_val`  out  16  running minimum.
- `count`  out  16  samples accepted into the statistics; saturates at 0xFFFF.
- `have_data`  out  1  at least one sample has been recorded since reset or clear.
- `out_valid`  out  1  one-cycle pulse when `max_val`/`min_val`/`count` have just been updated.
- `err`  out  1  sticky: comparator result was not one-hot at a capture.

## Operation
- States: IDLE, CMP_MAX, CMP_MIN.
- Accept: a sample is accepted on a rising edge with `in_valid` & `in_ready`.
- First sample (`have_data`=0):
  - Load `max_val` = `min_val` = `in_data`, `count`=1, `have_data`=1, `out_valid`=1.
  - Stay in IDLE. The comparator is not used.
- Later samples:
  - At the accept edge, latch the sample, set `cmp_a`=sample, `cmp_b`=`max_val`, clear the settle counter, and go to CMP_MAX.
- CMP_MAX:
  - The counter increments each edge.
  - At the edge where counter==SETTLE_CYCLES-1, capture {gt,eq,lt} and set new_max = gt ? sample : `max_val`.
  - Then set `cmp_b`=`min_val`, clear the counter, and go to CMP_MIN.
- CMP_MIN:
  - At the edge where counter==SETTLE_CYCLES-1, capture the result and set new_min = lt ? sample : `min_val`.
  - On that same edge write `max_val`/`min_val`, increment `count` (saturating), pulse `out_valid`, and go to IDLE.
- Equal results (eq=1) leave the compared register unchanged.
- Comparator check: at either capture, if {gt,eq,lt} is not exactly one-hot:
  - Set `err`, discard the sample, and go to IDLE.
  - No register update, no `count` change, no `out_valid`.
- `clear`:
  - Forces state IDLE and zeroes `max_val`, `min_val`, `count`, `have_data`, `err`, `cmp_a`, `cmp_b` and the counter.
  - Aborts any in-flight sample without an update.
  - `clear` together with `in_valid` drops the sample, because `in_ready`=0.
- Reset (`rst_n` low, asynchronous, any state):
  - State IDLE; every registered output is 0.
  - `in_ready`=1 once `clear` is low.

## Timing
- First sample:
  - Accept at edge N.
  - Statistics updated and `out_valid` high from edge N to edge N+1.
  - `in_ready` stays high, so back-to-back acceptance is allowed.
- Later samples:
  - Accept at edge N.
  - `cmp_a`/`cmp_b` valid after edge N.
  - Max result captured at edge N+SETTLE_CYCLES.
  - `cmp_b` switches to `min_val` after edge N+SETTLE_CYCLES.
  - Update and `out_valid` at edge N+2·SETTLE_CYCLES.
  - `in_ready` is low for 2·SETTLE_CYCLES cycles; the earliest next accept is edge N+2·SETTLE_CYCLES+1.
- `cmp_a`/`cmp_b` are stable for at least SETTLE_CYCLES full clock periods before every capture. At a 10 ns clock, SETTLE_CYCLES=2 covers the comparator's two-level propagation delay.
- `out_valid` is never high for two consecutive cycles on non-first samples.

## Test plan
- Reset, then one sample 0x1234 → `max_val`=`min_val`=0x1234, `count`=1, `have_data`=1, `out_valid` high exactly one cycle after the accept edge.
- With the real comparator and SETTLE_CYCLES=2, feed 0x0010, 0x8000, 0x0001, 0x8000 → `max_val`=0x8000, `min_val`=0x0001, `count`=4; `in_ready` low exactly 4 cycles after each non-first accept; the final 0x8000 takes the eq path with no change.
- Feed 0xFFFF, 0x0000, 0xFFFF → `max_val`=0xFFFF, `min_val`=0x0000, `count`=3, `err`=0.
- Force {`cmp_gt`,`cmp_eq`,`cmp_lt`}=3'b000 during CMP_MAX of the second sample → `err`=1 and stays 1; `count` stays 1; no `out_valid`; the next good sample is processed normally.
- Assert `clear` during CMP_MIN → no update; `count`=0, `have_data`=0, `max_val`=`min_val`=0; the next sample 0x0042 is loaded as a first sample.
- Drop `rst_n` mid CMP_MAX → all outputs 0 immediately without a clock edge; after release `in_ready`=1 and the next sample behaves as a first sample.
